vga_scan_timer: RTL and testbench

Raster timing generator upstream and downstream of the frame GPU (`f2_gpu`).
- It generates 640x480@60 Hz-class counters from `sysclk`.
- It presents the current raster position to the GPU as `display_addr`.
- It samples the GPU's `display_data` back and drives the VGA connector.
- It aligns hsync/vsync/blanking to the data return latency, so the picture lands on the 640x480 window the GPU's 16x16 cell mapping expects (x 112..751, y 7..486).

---
 rtl/vga_scan_timer_if.sv | 22 ++
 rtl/vga_scan_timer.sv | 118 +++++++++++
 tb/tb_vga_scan_timer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_timer_if.sv
// Raster timer bundle: GPU address/data loop plus the VGA connector outputs.
interface vga_scan_timer_if;
  logic [19:0] display_addr;
  logic [2:0]  display_data;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [2:0]  vga_rgb;
  logic        video_active;
  logic        frame_tick;

  // timer side: presents addresses, drives the connector, takes pixel data back
  modport master (
    output display_addr, vga_hsync, vga_vsync, vga_rgb, video_active, frame_tick,
    input  display_data
  );

  // GPU / display side
  modport slave (
    input  display_addr, vga_hsync, vga_vsync, vga_rgb, video_active, frame_tick,
    output display_data
  );
endinterface

// File: rtl/vga_scan_timer.sv
// 640x480@60-class raster timer. Presents {h,v} to the GPU, delays the
// decoded sync/blank set by DATA_LAT ticks so it lines up with the returned
// pixel data, then registers everything onto the VGA pins.
module vga_scan_timer #(
  parameter int CLK_DIV  = 2,  // sysclk cycles per pixel tick, 1..8
  parameter int DATA_LAT = 0   // ticks from display_addr to valid display_data, 0..3
) (
  input  logic             sysclk,
  input  logic             rst_n,
  vga_scan_timer_if.master vif
);
  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST   = 10'd799;
  localparam logic [9:0]    V_LAST   = 10'd524;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } tim_t;

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [9:0]    h_count;
  logic [9:0]    v_count;
  tim_t          raw;
  tim_t          aligned;
  logic          hsync_q;
  logic          vsync_q;
  logic          active_q;
  logic [2:0]    rgb_q;
  logic          frame_q;

  // with CLK_DIV=1 div_cnt sits at 0 and tick is permanently high
  assign tick = (div_cnt == DIV_LAST);

  // pixel-tick divider
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // raster counters; >= keeps them bounded even from an illegal state
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (tick) begin
      if (h_count >= H_LAST) begin
        h_count <= '0;
        v_count <= (v_count >= V_LAST) ? 10'd0 : v_count + 10'd1;
      end else begin
        h_count <= h_count + 10'd1;
      end
    end
  end

  assign vif.display_addr = {h_count, v_count};

  // sync/blank decode for the position currently presented to the GPU
  always_comb begin
    raw     = '0;
    raw.hs  = (h_count < 10'd96);
    raw.vs  = (v_count < 10'd2);
    raw.act = (h_count >= 10'd112) && (h_count <= 10'd751) &&
              (v_count >= 10'd7)   && (v_count <= 10'd486);
  end

  // delay line matching the GPU data return latency
  generate
    if (DATA_LAT == 0) begin : g_nolat
      assign aligned = raw;
    end else begin : g_lat
      tim_t pipe [DATA_LAT];

      // shift the decoded set one stage per tick
      always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DATA_LAT; i++) pipe[i] <= '0;
        end else if (tick) begin
          pipe[0] <= raw;
          for (int i = 1; i < DATA_LAT; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign aligned = pipe[DATA_LAT-1];
    end
  endgenerate

  // connector register: syncs active-low, colour blanked outside the window
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b0;
      rgb_q    <= 3'b000;
    end else if (tick) begin
      hsync_q  <= ~aligned.hs;
      vsync_q  <= ~aligned.vs;
      active_q <= aligned.act;
      rgb_q    <= aligned.act ? vif.display_data : 3'b000;
    end
  end

  // one-cycle pulse after the tick that wraps (799,524) -> (0,0)
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) frame_q <= 1'b0;
    else        frame_q <= tick && (h_count == H_LAST) && (v_count == V_LAST);
  end

  assign vif.vga_hsync    = hsync_q;
  assign vif.vga_vsync    = vsync_q;
  assign vif.video_active = active_q;
  assign vif.vga_rgb      = rgb_q;
  assign vif.frame_tick   = frame_q;
endmodule

// File: tb/tb_vga_scan_timer.sv
// Bench for vga_scan_timer: three instances (div2/lat0, div2/lat2, div1/lat0)
// checked every cycle against a raster model, plus directed line/frame/reset steps.
module tb_vga_scan_timer;
  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 sysclk = ~sysclk;

  vga_scan_timer_if vif0 ();
  vga_scan_timer_if vif1 ();
  vga_scan_timer_if vif2 ();

  vga_scan_timer #(.CLK_DIV(2), .DATA_LAT(0)) u0 (.sysclk(sysclk), .rst_n(rst_n), .vif(vif0));
  vga_scan_timer #(.CLK_DIV(2), .DATA_LAT(2)) u1 (.sysclk(sysclk), .rst_n(rst_n), .vif(vif1));
  vga_scan_timer #(.CLK_DIV(1), .DATA_LAT(0)) u2 (.sysclk(sysclk), .rst_n(rst_n), .vif(vif2));

  typedef struct packed { logic [9:0] h; logic [9:0] v; } pos_t;
  typedef struct packed { logic hsync; logic vsync; logic act; logic [2:0] rgb; } out_t;

  localparam out_t RST_OUT = '{hsync: 1'b1, vsync: 1'b1, act: 1'b0, rgb: 3'b000};

  int   n_vec = 0;
  int   n_err = 0;
  pos_t m0, m1, m2;
  int   mdiv;
  bit   wrap0, wrap1, wrap2;
  out_t e0, e2;
  out_t sb [$];
  logic [19:0] a0, a1, a2;
  int   pix [3];
  int   npix = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pos_t nxt(input pos_t p);
    pos_t n = p;
    if (p.h == 10'd799) begin
      n.h = 10'd0;
      n.v = (p.v == 10'd524) ? 10'd0 : p.v + 10'd1;
    end else begin
      n.h = p.h + 10'd1;
    end
    return n;
  endfunction

  function automatic bit is_end(input pos_t p);
    return (p.h == 10'd799) && (p.v == 10'd524);
  endfunction

  function automatic bit in_win(input pos_t p);
    return (p.h >= 112) && (p.h <= 751) && (p.v >= 7) && (p.v <= 486);
  endfunction

  function automatic out_t exp_out(input pos_t p, input logic [2:0] d);
    out_t o;
    o.hsync = !(p.h < 96);
    o.vsync = !(p.v < 2);
    o.act   = in_win(p);
    o.rgb   = o.act ? d : 3'b000;
    return o;
  endfunction

  // GPU stand-in: h[2:0] inside the window, all-ones outside to expose blanking
  function automatic logic [2:0] gpu(input logic [19:0] a);
    pos_t p = a;
    return in_win(p) ? p.h[2:0] : 3'b111;
  endfunction

  task automatic model_reset();
    mdiv = 0;
    m0 = '0; m1 = '0; m2 = '0;
    wrap0 = 0; wrap1 = 0; wrap2 = 0;
    e0 = RST_OUT; e2 = RST_OUT;
    sb.delete();
    sb.push_back(RST_OUT);
    sb.push_back(RST_OUT);
    sb.push_back(exp_out('0, 3'b000));
    a0 = '0; a1 = '0; a2 = '0;
    vif1.display_data = gpu(20'h0);
  endtask

  // one sysclk: advance the models, then check all three instances
  task automatic step();
    bit   t2;
    out_t e;
    @(posedge sysclk); #1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    mdiv++;
    t2 = (mdiv == 2);
    if (t2) mdiv = 0;
    wrap0 = 0; wrap1 = 0;
    wrap2 = is_end(m2);
    e2 = exp_out(m2, 3'b111);
    m2 = nxt(m2);
    if (t2) begin
      wrap0 = is_end(m0);
      e0 = exp_out(m0, 3'b111);
      m0 = nxt(m0);
      wrap1 = is_end(m1);
      m1 = nxt(m1);
      e = sb.pop_front();
      chk("u1_out", 32'({vif1.vga_hsync, vif1.vga_vsync, vif1.video_active, vif1.vga_rgb}), 32'(e));
      sb.push_back(exp_out(m1, m1.h[2:0]));
      if (vif1.video_active && npix < 3) begin
        pix[npix] = int'(vif1.vga_rgb);
        npix++;
      end
      a2 = a1; a1 = a0; a0 = vif1.display_addr;
      vif1.display_data = gpu(a2);
    end
    chk("u0_addr", 32'(vif0.display_addr), 32'(m0));
    chk("u1_addr", 32'(vif1.display_addr), 32'(m1));
    chk("u2_addr", 32'(vif2.display_addr), 32'(m2));
    chk("u0_out", 32'({vif0.vga_hsync, vif0.vga_vsync, vif0.video_active, vif0.vga_rgb}), 32'(e0));
    chk("u2_out", 32'({vif2.vga_hsync, vif2.vga_vsync, vif2.video_active, vif2.vga_rgb}), 32'(e2));
    chk("u0_ftick", 32'(vif0.frame_tick), 32'(wrap0));
    chk("u1_ftick", 32'(vif1.frame_tick), 32'(wrap1));
    chk("u2_ftick", 32'(vif2.frame_tick), 32'(wrap2));
  endtask

  // park u0's counters at p just after a tick, so the next tick advances from p
  task automatic jump_u0(input pos_t p);
    for (int k = 0; k < 4 && mdiv != 0; k++) step();
    force u0.h_count = p.h;
    force u0.v_count = p.v;
    m0 = p;
    step();
    release u0.h_count;
    release u0.v_count;
  endtask

  int   low [16];
  int   act [16];
  int   per [16];
  int   ln = -1, lfall = 0, ln2 = -1, lf2 = 0, per2 = 0;
  logic hs0_prev = 1'b1, hs2_prev = 1'b1;
  int   ftc, vsl;

  initial begin
    low = '{default: 0}; act = '{default: 0}; per = '{default: 0};
    vif0.display_data = 3'b111;
    vif2.display_data = 3'b111;
    vif1.display_data = 3'b111;

    // reset held for 5 cycles
    rst_n = 1'b0;
    repeat (5) step();
    chk("rst_addr",   32'(vif0.display_addr), 32'h0);
    chk("rst_hsync",  32'(vif0.vga_hsync), 32'h1);
    chk("rst_vsync",  32'(vif0.vga_vsync), 32'h1);
    chk("rst_rgb",    32'(vif0.vga_rgb), 32'h0);
    chk("rst_active", 32'(vif0.video_active), 32'h0);
    chk("rst_ftick",  32'(vif0.frame_tick), 32'h0);
    chk("rst_u1", 32'({vif1.display_addr, vif1.vga_hsync, vif1.vga_vsync, vif1.video_active, vif1.vga_rgb, vif1.frame_tick}), 32'({20'h0, 7'b1100000}));
    chk("rst_u2", 32'({vif2.display_addr, vif2.vga_hsync, vif2.vga_vsync, vif2.video_active, vif2.vga_rgb, vif2.frame_tick}), 32'({20'h0, 7'b1100000}));

    // release and run nine lines, gathering per-line stats
    rst_n = 1'b1;
    for (int i = 0; i < 15000; i++) begin
      step();
      if (i == 1) chk("addr_2nd_edge", 32'(vif0.display_addr), 32'h00400);
      if (hs0_prev && !vif0.vga_hsync) begin
        ln++;
        if (ln > 0 && ln < 16) per[ln] = i - lfall;
        lfall = i;
      end
      hs0_prev = vif0.vga_hsync;
      if (ln >= 0 && ln < 16) begin
        low[ln] += vif0.vga_hsync ? 0 : 1;
        act[ln] += vif0.video_active ? 1 : 0;
      end
      if (hs2_prev && !vif2.vga_hsync) begin
        ln2++;
        if (ln2 == 1) per2 = i - lf2;
        lf2 = i;
      end
      hs2_prev = vif2.vga_hsync;
    end
    chk("hsync_low_l1", 32'(low[1]), 32'd192);
    chk("line_period",  32'(per[1]), 32'd1600);
    chk("active_l6",    32'(act[6]), 32'd0);
    chk("active_l7",    32'(act[7]), 32'd1280);
    chk("div1_period",  32'(per2), 32'd800);
    chk("first_pix",    32'(pix[0]), 32'd0);
    chk("second_pix",   32'(pix[1]), 32'd1);
    chk("third_pix",    32'(pix[2]), 32'd2);

    // frame wrap on u0
    jump_u0('{h: 10'd797, v: 10'd524});
    ftc = 0; vsl = 0;
    for (int i = 0; i < 4000; i++) begin
      step();
      if (vif0.frame_tick) begin
        ftc++;
        chk("wrap_addr", 32'(vif0.display_addr), 32'h0);
      end
      vsl += vif0.vga_vsync ? 0 : 1;
    end
    chk("ftick_count", 32'(ftc), 32'd1);
    chk("vsync_low",   32'(vsl), 32'd3200);

    // reset in mid-frame at (400,200)
    jump_u0('{h: 10'd399, v: 10'd200});
    step();
    chk("pre_rst_active", 32'(vif0.video_active), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(vif0.display_addr), 32'h0);
    chk("mid_rst_out", 32'({vif0.vga_hsync, vif0.vga_vsync, vif0.video_active, vif0.vga_rgb, vif0.frame_tick}), 32'(7'b1100000));
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i == 1) chk("restart_addr", 32'(vif0.display_addr), 32'h00400);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
